// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parameterised VGA raster timing generator; all outputs are
//               registered and decoded from the same next-counter values.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC_W = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC_W = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          h_sync,
  output logic          v_sync,
  output logic          rgb_en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          v_blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC_W + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC_W + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC_W);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC_W);

  logic [CW-1:0] w_x_nxt;
  logic [CW-1:0] w_y_nxt;

  // x/y are themselves the counters; the decode below looks at the values
  // being loaded so every output lines up with the coordinates it reports.
  always_comb begin
    w_x_nxt = x;
    w_y_nxt = y;
    if (ce) begin
      if (x == H_LAST) begin
        w_x_nxt = '0;
        w_y_nxt = (y == V_LAST) ? '0 : y + CW'(1);
      end else begin
        w_x_nxt = x + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x           <= H_LAST;
      y           <= V_LAST;
      rgb_en      <= 1'b0;
      v_blank     <= 1'b1;
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= w_x_nxt;
      y           <= w_y_nxt;
      rgb_en      <= (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
      v_blank     <= (w_y_nxt >= V_VIS);
      h_sync      <= ((w_x_nxt >= HS_FIRST) && (w_x_nxt < HS_END)) ? H_POL : ~H_POL;
      v_sync      <= ((w_y_nxt >= VS_FIRST) && (w_y_nxt < VS_END)) ? V_POL : ~V_POL;
      // A pulse needs an actual step onto x=0, not merely holding there.
      line_start  <= ce && (w_x_nxt == '0);
      frame_start <= ce && (w_x_nxt == '0) && (w_y_nxt == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen; a small-raster and a
//               default-raster instance run from shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  always #5 clk = ~clk;

  logic       hs_s, vs_s, rgb_s, ls_s, fs_s, vb_s;
  logic [3:0] x_s, y_s;
  logic       hs_d, vs_d, rgb_d, ls_d, fs_d, vb_d;
  logic [9:0] x_d, y_d;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC_W(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC_W(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b0), .CW(4)
  ) u_small (
    .clk(clk), .rst(rst), .ce(ce),
    .h_sync(hs_s), .v_sync(vs_s), .rgb_en(rgb_s), .x(x_s), .y(y_s),
    .line_start(ls_s), .frame_start(fs_s), .v_blank(vb_s)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .rst(rst), .ce(ce),
    .h_sync(hs_d), .v_sync(vs_d), .rgb_en(rgb_d), .x(x_d), .y(y_d),
    .line_start(ls_d), .frame_start(fs_d), .v_blank(vb_d)
  );

  typedef struct packed {
    logic       hs, vs, rgb, ls, fs, vb;
    logic [9:0] x, y;
  } exp_t;

  exp_t q_s[$];
  exp_t q_d[$];
  int   tests = 0;
  int   fails = 0;
  int   p_s, p_d;   // linear pixel index within the frame

  localparam int TOT_S = 14 * 7;
  localparam int TOT_D = 800 * 525;

  // Expected outputs for a raster position, straight from the region rules.
  function automatic exp_t expect_at(input int p, input bit stepped,
                                     input int ha, hf, hw, hb,
                                     input int va, vf, vw, input bit hp, vp);
    exp_t e;
    int ht, xx, yy;
    ht    = ha + hf + hw + hb;
    xx    = p % ht;
    yy    = p / ht;
    e.x   = 10'(xx);
    e.y   = 10'(yy);
    e.rgb = (xx < ha) && (yy < va);
    e.vb  = (yy >= va);
    e.hs  = (xx >= ha + hf && xx < ha + hf + hw) ? hp : ~hp;
    e.vs  = (yy >= va + vf && yy < va + vf + vw) ? vp : ~vp;
    e.ls  = stepped && (xx == 0);
    e.fs  = stepped && (p == 0);
    return e;
  endfunction

  task automatic step(input bit r, input bit c);
    @(negedge clk);
    rst = r;
    ce  = c;
    if (r) begin
      p_s = TOT_S - 1;
      p_d = TOT_D - 1;
    end else if (c) begin
      p_s = (p_s + 1) % TOT_S;
      p_d = (p_d + 1) % TOT_D;
    end
    q_s.push_back(expect_at(p_s, c && !r, 8, 2, 3, 1, 4, 1, 1, 1'b1, 1'b0));
    q_d.push_back(expect_at(p_d, c && !r, 640, 16, 96, 48, 480, 10, 2, 1'b0, 1'b0));
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
    end
  endtask

  // Monitor: outputs are valid every clock, so one entry is consumed per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_s.size() > 0) begin
        e = q_s.pop_front();
        chk("small.x", int'(x_s), int'(e.x));
        chk("small.y", int'(y_s), int'(e.y));
        chk("small.h_sync", int'(hs_s), int'(e.hs));
        chk("small.v_sync", int'(vs_s), int'(e.vs));
        chk("small.rgb_en", int'(rgb_s), int'(e.rgb));
        chk("small.v_blank", int'(vb_s), int'(e.vb));
        chk("small.line_start", int'(ls_s), int'(e.ls));
        chk("small.frame_start", int'(fs_s), int'(e.fs));
      end
      if (q_d.size() > 0) begin
        e = q_d.pop_front();
        chk("dflt.x", int'(x_d), int'(e.x));
        chk("dflt.y", int'(y_d), int'(e.y));
        chk("dflt.h_sync", int'(hs_d), int'(e.hs));
        chk("dflt.v_sync", int'(vs_d), int'(e.vs));
        chk("dflt.rgb_en", int'(rgb_d), int'(e.rgb));
        chk("dflt.v_blank", int'(vb_d), int'(e.vb));
        chk("dflt.line_start", int'(ls_d), int'(e.ls));
        chk("dflt.frame_start", int'(fs_d), int'(e.fs));
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0);
    // release into (0,0) then two full small frames
    repeat (2 * TOT_S + 20) step(1'b0, 1'b1);
    // pixel enable one clock in four
    for (int i = 0; i < 400; i++) step(1'b0, (i % 4) == 0);
    // reset mid-frame with CE high, then restart
    step(1'b1, 1'b1);
    repeat (50) step(1'b0, 1'b1);
    // randomized enable with occasional resets
    repeat (3000) step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0);
    // clean reset, then two default-sized lines with CE held high
    step(1'b1, 1'b0);
    repeat (1700) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    if (q_s.size() != 0 || q_d.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", q_s.size(), q_d.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC_W, default 96: horizontal sync width, in pixels.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC_W, default 2: vertical sync width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 Parameter H_POL, default 0, and parameter V_POL, default 0: active level of H_SYNC and V_SYNC (0 = active-low).
REQ-010 Parameter CW, default 10: counter and coordinate width; CW SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-011 CLK  input  1  single clock; all state changes on the rising edge.
REQ-012 RST  input  1  synchronous, active-high reset.
REQ-013 CE  input  1  pixel-advance enable; counters step only when CE=1.
REQ-014 H_SYNC  output  1  horizontal sync at H_POL level while in the sync region.
REQ-015 V_SYNC  output  1  vertical sync at V_POL level while in the sync region.
REQ-016 RGB_EN  output  1  high only in the visible area.
REQ-017 X  output  CW  current horizontal position (h counter).
REQ-018 Y  output  CW  current vertical position (v counter).
REQ-019 LINE_START  output  1  one-CLK pulse on entry to X=0.
REQ-020 FRAME_START  output  1  one-CLK pulse on entry to X=0, Y=0.
REQ-021 V_BLANK  output  1  high while Y >= V_ACTIVE.

Function
REQ-022 H_TOTAL = H_ACTIVE+H_FP+H_SYNC_W+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC_W+V_BP; every parameter SHALL be >= 1.
REQ-023 Line order: active [0, H_ACTIVE-1], front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC_W-1], back porch to H_TOTAL-1; vertical order is identical, in lines.
REQ-024 On a CLK edge with CE=1, h increments; at h=H_TOTAL-1, h wraps to 0 and v increments; at v=V_TOTAL-1 with the h wrap, v wraps to 0.
REQ-025 On an edge with CE=0, h and v SHALL hold.
REQ-026 All outputs are registered and SHALL be decoded from the counter values loaded on the same edge, giving zero skew between X/Y and the syncs/enables.
REQ-027 RGB_EN SHALL equal (X < H_ACTIVE) AND (Y < V_ACTIVE).
REQ-028 V_SYNC SHALL change only coincident with h wrapping to 0.
REQ-029 LINE_START and FRAME_START SHALL be high for exactly one CLK cycle after the CE edge that enters the qualifying position, and low on the next CLK edge regardless of CE.
REQ-030 Arithmetic SHALL be unsigned at CW bits; no counter exceeds H_TOTAL-1 or V_TOTAL-1.

Reset
REQ-031 When RST=1 at an edge, h SHALL load H_TOTAL-1 and v SHALL load V_TOTAL-1; RST SHALL take priority over CE.
REQ-032 Output values under reset: X=H_TOTAL-1, Y=V_TOTAL-1, RGB_EN=0, V_BLANK=1, H_SYNC=~H_POL, V_SYNC=~V_POL, LINE_START=0, FRAME_START=0.
REQ-033 RST asserted mid-frame SHALL abort the frame with no partial pulse; the first CE edge after release SHALL produce X=0, Y=0, FRAME_START=1.

Verification
REQ-034 Assert RST, then release with CE=1 for one edge -> X=0, Y=0, RGB_EN=1, LINE_START=1, FRAME_START=1, V_BLANK=0.
REQ-035 Hold CE=1 with default parameters -> H_SYNC=0 exactly for X=656..751 (96 cycles), line period 800, RGB_EN high for 307200 cycles per frame.
REQ-036 Run CE=1 for two frames -> FRAME_START period 420000 cycles; V_SYNC=0 for Y=490..491 (1600 cycles), entering and leaving at X=0.
REQ-037 Drive CE=1 one cycle in four -> all periods scale by 4 (line period 3200 CLK); LINE_START and FRAME_START remain one CLK wide.
REQ-038 Assert RST for one cycle at X=300, Y=100 -> the next cycle shows reset values (X=799, Y=524, RGB_EN=0), then normal restart at (0,0).
REQ-039 Use H_ACTIVE=8, H_FP=2, H_SYNC_W=3, H_BP=1, V params 4/1/1/1, H_POL=1 -> H_SYNC=1 only for X=10..12, X wraps 13->0, V_SYNC=0 only for Y=5.
